// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit MULT/MULTU/DIV/DIVU unit returning {HI,LO}
module mul_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic                flush,
  input  logic [DATA_W-1:0]   src_a,
  input  logic [DATA_W-1:0]   src_b,
  output logic                busy,
  output logic                done,
  output logic [2*DATA_W-1:0] result
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  // acc holds {product_hi, multiplier/product_lo} for multiply and
  // {partial_rem, dividend/quotient} for divide.
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   opnd;
  logic                is_div;
  logic                sign_a;
  logic                sign_b;
  logic                b_zero;

  logic                is_signed_in;
  logic                a_neg_in;
  logic                b_neg_in;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [DATA_W:0]     div_shift;
  logic [DATA_W:0]     div_diff;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;
  logic [2*DATA_W-1:0] fix_val;

  // Operand magnitudes and one radix-2 step for each operation type
  always_comb begin
    is_signed_in = ~op[0];
    a_neg_in     = is_signed_in & src_a[DATA_W-1];
    b_neg_in     = is_signed_in & src_b[DATA_W-1];
    a_mag        = a_neg_in ? (~src_a + 1'b1) : src_a;
    b_mag        = b_neg_in ? (~src_b + 1'b1) : src_b;
    mul_sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    div_shift    = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    div_diff     = div_shift - {1'b0, opnd};
  end

  // Sign correction of the magnitude result; divide-by-zero forces an all-ones quotient
  always_comb begin
    quot_fix = acc[DATA_W-1:0];
    rem_fix  = acc[2*DATA_W-1:DATA_W];
    fix_val  = acc;
    if (is_div) begin
      if (b_zero) begin
        quot_fix = {DATA_W{1'b1}};
      end else if (sign_a ^ sign_b) begin
        quot_fix = ~acc[DATA_W-1:0] + 1'b1;
      end
      if (sign_a) begin
        rem_fix = ~acc[2*DATA_W-1:DATA_W] + 1'b1;
      end
      fix_val = {rem_fix, quot_fix};
    end else if (sign_a ^ sign_b) begin
      fix_val = ~acc + 1'b1;
    end
  end

  // Control FSM with registered busy/done/result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      b_zero <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              is_div <= op[1];
              sign_a <= a_neg_in;
              sign_b <= b_neg_in;
              b_zero <= (src_b == '0);
              cnt    <= '0;
              if (op[1]) begin
                acc  <= {{DATA_W{1'b0}}, a_mag};
                opnd <= b_mag;
              end else begin
                acc  <= {{DATA_W{1'b0}}, b_mag};
                opnd <= a_mag;
              end
              busy  <= 1'b1;
              state <= CALC;
            end
          end
          CALC: begin
            if (is_div) begin
              if (!div_diff[DATA_W]) begin
                acc <= {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
              end else begin
                acc <= {div_shift[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
              end
            end else begin
              acc <= {mul_sum, acc[DATA_W-1:1]};
            end
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(DATA_W - 1)) begin
              state <= FIX;
            end
          end
          FIX: begin
            result <= fix_val;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against an arithmetic reference
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        flush;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int applied;
  int miscompares;
  logic [63:0] last_result;

  mul_div_unit #(.DATA_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .flush  (flush),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int     ia;
    int     ib;
    longint p;
    int     q;
    int     r;
    ia = a;
    ib = b;
    case (o)
      2'b00: begin
        p = longint'(ia) * longint'(ib);
        return p;
      end
      2'b01: return {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = ia / ib;
        r = ia % ib;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    applied++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge, leaves at the negedge of the done cycle (or after the bound)
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold_start);
    logic [63:0] exp;
    int n;
    exp   = ref_model(o, a, b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " busy_after_start"}, {63'd0, busy}, 64'd1);
    n = 0;
    while (!done && n < 100) begin
      if (n >= hold_start) start = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(n), 64'd33);
    check({tag, " result"}, result, exp);
    check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    last_result = exp;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int          seen_done;

    applied     = 0;
    miscompares = 0;
    last_result = 64'd0;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    flush = 1'b0;
    src_a = 32'd0;
    src_b = 32'd0;

    repeat (2) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset result", result, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg1x2", 2'b00, 32'hFFFF_FFFF, 32'd2, 0);
    check("mult_neg1x2 literal", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu_max_x2", 2'b01, 32'hFFFF_FFFF, 32'd2, 0);
    check("multu literal", result, 64'h0000_0001_FFFF_FFFE);
    run_op("mult_minxmin", 2'b00, 32'h8000_0000, 32'h8000_0000, 0);
    check("mult_minxmin literal", result, 64'h4000_0000_0000_0000);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_m7_2 literal", result, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 0);
    check("divu_100_7 literal", result, 64'h0000_0002_0000_000E);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_ovf literal", result, 64'h0000_0000_8000_0000);
    run_op("divu_5_0", 2'b11, 32'd5, 32'd0, 0);
    check("divu_5_0 literal", result, 64'h0000_0005_FFFF_FFFF);
    // back-to-back: the next start is driven in the done cycle
    run_op("b2b_div_m9_0", 2'b10, 32'hFFFF_FFF7, 32'd0, 0);
    run_op("b2b_mult", 2'b00, 32'd12345, 32'hFFFF_FF00, 0);

    // start held high while busy must not disturb the operation
    run_op("start_while_busy", 2'b10, 32'd1000, 32'hFFFF_FFFD, 8);

    // flush at the 10th CALC cycle
    op    = 2'b01;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h1234_5678;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {63'd0, busy}, 64'd0);
    check("flush done", {63'd0, done}, 64'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    check("flush no_done", 64'(seen_done), 64'd0);
    check("flush result_kept", result, last_result);

    // asynchronous reset during CALC cycle 5
    op    = 2'b00;
    src_a = 32'h7FFF_FFFF;
    src_b = 32'h7FFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst busy", {63'd0, busy}, 64'd0);
    check("rst done", {63'd0, done}, 64'd0);
    check("rst result", result, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_rst", 2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);

    // randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op("random", ro, ra, rb, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
